// File: rtl/msi_wb_bfm_slave.sv
// ============================================================================
//  Module   : msi_wb_bfm_slave
//  Purpose  : Wishbone B3 slave handshake engine driven by a parent model.
//             The parent sees each pending transfer through the public state
//             outputs. It answers with a one-cycle write-ack, read-ack or
//             error command.
//  Revision : 1.0  initial release
// ============================================================================
//
//  Parent-side protocol (clocked on wb_clk rising edge):
//    * A transfer becomes visible when req_valid_o is high. The state outputs
//      address_o, op_o, mask_o, cycle_type_o and has_next_o describe it.
//    * The parent answers by holding exactly one of write_ack_i, read_ack_i
//      or error_i high at the next rising edge. For read_ack_i it also
//      supplies rd_data_i. Wishbone ack/err rise just after that edge.
//    * The parent inserts wait states by leaving all command inputs low on
//      edges where req_valid_o is high.
//    * Write data and mask are captured on the edge that completes the beat.
//      wr_valid_o pulses for one cycle with wr_data_o/mask_o valid.
//    * During a burst, req_valid_o is already high while the current ack is
//      on the bus. A command on that edge keeps ack high continuously, which
//      gives one beat per cycle.
// ============================================================================
`default_nettype none

module msi_wb_bfm_slave #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEBUG = 0
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    // Wishbone slave port
    input  logic [AW-1:0]     wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic [1:0]        wb_bte_i,
    input  logic [2:0]        wb_cti_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    // Parent-model side: public transfer state
    output logic              req_valid_o,
    output logic [AW-1:0]     address_o,
    output logic              op_o,
    output logic [DW/8-1:0]   mask_o,
    output logic              cycle_type_o,
    output logic              has_next_o,
    output logic [DW-1:0]     wr_data_o,
    output logic              wr_valid_o,
    // Parent-model side: response commands
    input  logic              write_ack_i,
    input  logic              read_ack_i,
    input  logic [DW-1:0]     rd_data_i,
    input  logic              error_i,
    // Beat marker for bench-side tracing; active only when DEBUG != 0
    output logic              dbg_beat_o
);

    localparam int c_NBYTES = DW / 8;

    localparam logic       c_OP_READ       = 1'b0;
    localparam logic       c_OP_WRITE      = 1'b1;
    localparam logic       c_CLASSIC_CYCLE = 1'b0;
    localparam logic       c_BURST_CYCLE   = 1'b1;
    localparam logic [2:0] c_CTI_CONST     = 3'b001;
    localparam logic [2:0] c_CTI_INCR      = 3'b010;
    localparam logic [2:0] c_CTI_EOB       = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for cyc & stb
        S_REQ  = 2'd1,   // beat pending, parent deciding (wait states)
        S_RESP = 2'd2    // ack or err on the bus this cycle
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       address_q;
    logic                op_q;
    logic [DW/8-1:0]     mask_q;
    logic                cycle_type_q;
    logic                has_next_q;
    logic [DW-1:0]       dat_o_q;
    logic                ack_q;
    logic                err_q;
    logic [DW-1:0]       wr_data_q;
    logic                wr_valid_q;

    logic                has_next_d;
    logic                issue_d;
    logic [AW-1:0]       adr_next_d;

    // Next beat address of a burst. A constant burst keeps the address.
    // An incrementing burst adds one bus word, linearly or wrapping on a
    // 4/8/16-beat boundary selected by bte.
    function automatic logic [AW-1:0] f_next_adr(
        input logic [AW-1:0] adr,
        input logic [2:0]    cti,
        input logic [1:0]    bte
    );
        logic [AW-1:0] inc;
        logic [AW-1:0] wmask;
        inc = adr + AW'(c_NBYTES);
        case (bte)
            2'b01:   wmask = AW'(4  * c_NBYTES - 1);
            2'b10:   wmask = AW'(8  * c_NBYTES - 1);
            2'b11:   wmask = AW'(16 * c_NBYTES - 1);
            default: wmask = '1;
        endcase
        if (cti == c_CTI_INCR) begin
            f_next_adr = (adr & ~wmask) | (inc & wmask);
        end else begin
            f_next_adr = adr;
        end
    endfunction

    // A burst continues past the completing beat unless the master has
    // flagged end-of-burst or has already dropped the cycle.
    always_comb begin
        has_next_d  = (cycle_type_q == c_BURST_CYCLE) && wb_cyc_i && (wb_cti_i != c_CTI_EOB);
        adr_next_d  = f_next_adr(address_q, wb_cti_i, wb_bte_i);
        req_valid_o = ((state_q == S_REQ)  && wb_cyc_i && wb_stb_i) ||
                      ((state_q == S_RESP) && ack_q && has_next_d && wb_stb_i);
        issue_d     = req_valid_o && (error_i || write_ack_i || read_ack_i);
    end

    // Handshake FSM with registered bus responses and parent-visible state.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q      <= S_IDLE;
            address_q    <= '0;
            op_q         <= c_OP_READ;
            mask_q       <= '0;
            cycle_type_q <= c_CLASSIC_CYCLE;
            has_next_q   <= 1'b0;
            dat_o_q      <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        address_q    <= wb_adr_i;
                        op_q         <= wb_we_i ? c_OP_WRITE : c_OP_READ;
                        mask_q       <= wb_sel_i;
                        cycle_type_q <= ((wb_cti_i == c_CTI_CONST) || (wb_cti_i == c_CTI_INCR))
                                        ? c_BURST_CYCLE : c_CLASSIC_CYCLE;
                        has_next_q   <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Master abandoned the cycle before any response.
                    if (!wb_cyc_i) begin
                        has_next_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                S_RESP: begin
                    // This edge completes the beat that was acknowledged.
                    if (ack_q) begin
                        if (op_q == c_OP_WRITE) begin
                            wr_data_q  <= wb_dat_i;
                            mask_q     <= wb_sel_i;
                            wr_valid_q <= 1'b1;
                        end
                        has_next_q <= has_next_d;
                        if (has_next_d) begin
                            address_q <= adr_next_d;
                        end
                    end
                    state_q <= (ack_q && has_next_d) ? S_REQ : S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase

            // Parent command: overrides the defaults above on the same edge.
            if (issue_d) begin
                if (error_i) begin
                    err_q      <= 1'b1;
                    has_next_q <= 1'b0;
                end else begin
                    ack_q <= 1'b1;
                    if (read_ack_i) begin
                        dat_o_q <= rd_data_i;
                    end
                end
                state_q <= S_RESP;
            end
        end
    end

    assign wb_dat_o     = dat_o_q;
    assign wb_ack_o     = ack_q;
    assign wb_err_o     = err_q;
    assign wb_rty_o     = 1'b0;

    assign address_o    = address_q;
    assign op_o         = op_q;
    assign mask_o       = mask_q;
    assign cycle_type_o = cycle_type_q;
    assign has_next_o   = has_next_q;
    assign wr_data_o    = wr_data_q;
    assign wr_valid_o   = wr_valid_q;

    assign dbg_beat_o   = (DEBUG != 0) && (ack_q || err_q);

endmodule

`default_nettype wire

// File: tb/tb_msi_wb_bfm_slave.sv
// ============================================================================
//  Module   : tb_msi_wb_bfm_slave
//  Purpose  : Directed self-checking bench for msi_wb_bfm_slave.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_msi_wb_bfm_slave;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     wb_adr_i  = '0;
    logic [DW-1:0]     wb_dat_i  = '0;
    logic [DW/8-1:0]   wb_sel_i  = '0;
    logic              wb_we_i   = 1'b0;
    logic [1:0]        wb_bte_i  = 2'b00;
    logic [2:0]        wb_cti_i  = 3'b000;
    logic              wb_cyc_i  = 1'b0;
    logic              wb_stb_i  = 1'b0;
    logic [DW-1:0]     wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic              wb_rty_o;
    logic              req_valid_o;
    logic [AW-1:0]     address_o;
    logic              op_o;
    logic [DW/8-1:0]   mask_o;
    logic              cycle_type_o;
    logic              has_next_o;
    logic [DW-1:0]     wr_data_o;
    logic              wr_valid_o;
    logic              write_ack_i = 1'b0;
    logic              read_ack_i  = 1'b0;
    logic [DW-1:0]     rd_data_i   = '0;
    logic              error_i     = 1'b0;
    logic              dbg_beat_o;

    int n_cmp  = 0;
    int n_fail = 0;

    msi_wb_bfm_slave #(.AW(AW), .DW(DW), .DEBUG(0)) dut (
        .wb_clk       (clk),
        .wb_rst       (rst),
        .wb_adr_i     (wb_adr_i),
        .wb_dat_i     (wb_dat_i),
        .wb_sel_i     (wb_sel_i),
        .wb_we_i      (wb_we_i),
        .wb_bte_i     (wb_bte_i),
        .wb_cti_i     (wb_cti_i),
        .wb_cyc_i     (wb_cyc_i),
        .wb_stb_i     (wb_stb_i),
        .wb_dat_o     (wb_dat_o),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .wb_rty_o     (wb_rty_o),
        .req_valid_o  (req_valid_o),
        .address_o    (address_o),
        .op_o         (op_o),
        .mask_o       (mask_o),
        .cycle_type_o (cycle_type_o),
        .has_next_o   (has_next_o),
        .wr_data_o    (wr_data_o),
        .wr_valid_o   (wr_valid_o),
        .write_ack_i  (write_ack_i),
        .read_ack_i   (read_ack_i),
        .rd_data_i    (rd_data_i),
        .error_i      (error_i),
        .dbg_beat_o   (dbg_beat_o)
    );

    always #5 clk = ~clk;

    // Present one master request (called just after a rising edge).
    task automatic bus_req(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
        wb_cti_i = cti; wb_bte_i = bte; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
        write_ack_i = 1'b0; read_ack_i = 1'b0; error_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", wb_ack_o); end
        n_cmp++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", wb_err_o); end
        n_cmp++; if (wb_rty_o !== 1'b0) begin n_fail++; $display("FAIL rst_rty: got %b want 0", wb_rty_o); end
        n_cmp++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL rst_has_next: got %b want 0", has_next_o); end
        @(posedge clk); #3 rst = 1'b0;
    endtask

    task automatic test_classic_write();
        @(posedge clk); #1 bus_req(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00);
        @(posedge clk); #1;
        n_cmp++; if (req_valid_o !== 1'b1) begin n_fail++; $display("FAIL cw_req_valid: got %b want 1", req_valid_o); end
        n_cmp++; if (op_o !== 1'b1) begin n_fail++; $display("FAIL cw_op: got %b want 1", op_o); end
        n_cmp++; if (cycle_type_o !== 1'b0) begin n_fail++; $display("FAIL cw_cycle_type: got %b want 0", cycle_type_o); end
        n_cmp++; if (address_o !== 32'h10) begin n_fail++; $display("FAIL cw_address: got %h want 10", address_o); end
        n_cmp++; if (has_next_o !== 1'b1) begin n_fail++; $display("FAIL cw_has_next_init: got %b want 1", has_next_o); end
        write_ack_i = 1'b1;
        @(posedge clk); #1 write_ack_i = 1'b0;
        n_cmp++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL cw_ack_high: got %b want 1", wb_ack_o); end
        @(posedge clk); #1;
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL cw_ack_one_cycle: got %b want 0", wb_ack_o); end
        n_cmp++; if (wr_valid_o !== 1'b1) begin n_fail++; $display("FAIL cw_wr_valid: got %b want 1", wr_valid_o); end
        n_cmp++; if (wr_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cw_data: got %h want deadbeef", wr_data_o); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL cw_has_next: got %b want 0", has_next_o); end
        bus_idle();
    endtask

    task automatic test_classic_read_delay();
        @(posedge clk); #1 bus_req(32'h14, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        @(posedge clk); #1;
        n_cmp++; if (op_o !== 1'b0) begin n_fail++; $display("FAIL cr_op: got %b want 0", op_o); end
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL cr_ack_wait: got %b want 0", wb_ack_o); end
        end
        read_ack_i = 1'b1; rd_data_i = 32'h12345678;
        @(posedge clk); #1 read_ack_i = 1'b0;
        n_cmp++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL cr_ack_at_4: got %b want 1", wb_ack_o); end
        n_cmp++; if (wb_dat_o !== 32'h12345678) begin n_fail++; $display("FAIL cr_dat: got %h want 12345678", wb_dat_o); end
        n_cmp++; if ({wb_err_o, wb_rty_o} !== 2'b00) begin n_fail++; $display("FAIL cr_err_rty: got %b want 00", {wb_err_o, wb_rty_o}); end
        @(posedge clk); #1;
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL cr_ack_low: got %b want 0", wb_ack_o); end
        n_cmp++; if (wb_dat_o !== 32'h12345678) begin n_fail++; $display("FAIL cr_dat_hold: got %h want 12345678", wb_dat_o); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL cr_has_next: got %b want 0", has_next_o); end
        bus_idle();
    endtask

    task automatic test_burst_write();
        logic [31:0] d [4];
        logic [2:0]  c [4];
        logic [3:0]  hn;
        d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333; d[3] = 32'h44444444;
        c[0] = 3'b010; c[1] = 3'b010; c[2] = 3'b010; c[3] = 3'b111;
        hn = 4'b0111;   // has_next after beats 0..3 (bit i): 1,1,1,0
        @(posedge clk); #1 bus_req(32'h20, 1'b1, d[0], 4'hF, c[0], 2'b00);
        @(posedge clk); #1;
        n_cmp++; if (cycle_type_o !== 1'b1) begin n_fail++; $display("FAIL bw_cycle_type: got %b want 1", cycle_type_o); end
        write_ack_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL bw_ack_beat0: got %b want 1", wb_ack_o); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (wr_data_o !== d[i]) begin n_fail++; $display("FAIL bw_data[%0d]: got %h want %h", i, wr_data_o, d[i]); end
            n_cmp++; if (has_next_o !== hn[i]) begin n_fail++; $display("FAIL bw_has_next[%0d]: got %b want %b", i, has_next_o, hn[i]); end
            n_cmp++; if (wb_ack_o !== hn[i]) begin n_fail++; $display("FAIL bw_ack_cont[%0d]: got %b want %b", i, wb_ack_o, hn[i]); end
            if (i < 3) begin
                n_cmp++; if (address_o !== 32'h20 + 32'(4 * (i + 1))) begin n_fail++; $display("FAIL bw_addr[%0d]: got %h want %h", i, address_o, 32'h20 + 32'(4 * (i + 1))); end
                wb_adr_i = 32'h20 + 32'(4 * (i + 1)); wb_dat_i = d[i+1]; wb_cti_i = c[i+1];
            end
        end
        bus_idle();
    endtask

    task automatic test_partial_write();
        @(posedge clk); #1 bus_req(32'h30, 1'b1, 32'hA1B2C3D4, 4'b0101, 3'b000, 2'b00);
        @(posedge clk); #1;
        n_cmp++; if (mask_o !== 4'b0101) begin n_fail++; $display("FAIL pw_mask_init: got %b want 0101", mask_o); end
        write_ack_i = 1'b1;
        @(posedge clk); #1 write_ack_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mask_o !== 4'b0101) begin n_fail++; $display("FAIL pw_mask: got %b want 0101", mask_o); end
        n_cmp++; if (wr_data_o !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL pw_data: got %h want a1b2c3d4", wr_data_o); end
        bus_idle();
    endtask

    task automatic test_error();
        @(posedge clk); #1 bus_req(32'hF000_0000, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        @(posedge clk); #1 error_i = 1'b1;
        @(posedge clk); #1 error_i = 1'b0;
        n_cmp++; if (wb_err_o !== 1'b1) begin n_fail++; $display("FAIL err_high: got %b want 1", wb_err_o); end
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL err_ack: got %b want 0", wb_ack_o); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL err_has_next: got %b want 0", has_next_o); end
        @(posedge clk); #1;
        n_cmp++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", wb_err_o); end
        bus_idle();
    endtask

    task automatic test_wrap_burst_read();
        @(posedge clk); #1 bus_req(32'h1C, 1'b0, 32'h0, 4'hF, 3'b010, 2'b01);
        @(posedge clk); #1 read_ack_i = 1'b1; rd_data_i = 32'hBEEF0001;
        @(posedge clk); #1 rd_data_i = 32'hBEEF0002;
        n_cmp++; if (wb_dat_o !== 32'hBEEF0001) begin n_fail++; $display("FAIL wr_dat0: got %h want beef0001", wb_dat_o); end
        @(posedge clk); #1;
        n_cmp++; if (address_o !== 32'h10) begin n_fail++; $display("FAIL wr_wrap_addr: got %h want 10", address_o); end
        n_cmp++; if (wb_dat_o !== 32'hBEEF0002) begin n_fail++; $display("FAIL wr_dat1: got %h want beef0002", wb_dat_o); end
        n_cmp++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL wr_ack_cont: got %b want 1", wb_ack_o); end
        wb_adr_i = 32'h10; wb_cti_i = 3'b111;
        @(posedge clk); #1;
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL wr_ack_end: got %b want 0", wb_ack_o); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL wr_has_next_end: got %b want 0", has_next_o); end
        bus_idle();
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1 bus_req(32'h50, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        @(posedge clk);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        n_cmp++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rw_dat: got %h want 0", wb_dat_o); end
        n_cmp++; if ({wb_ack_o, wb_err_o, wb_rty_o} !== 3'b000) begin n_fail++; $display("FAIL rw_resp: got %b want 000", {wb_ack_o, wb_err_o, wb_rty_o}); end
        n_cmp++; if (has_next_o !== 1'b0) begin n_fail++; $display("FAIL rw_has_next: got %b want 0", has_next_o); end
        n_cmp++; if (req_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_req_valid: got %b want 0", req_valid_o); end
        bus_idle();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1 bus_req(32'h40, 1'b0, 32'h0, 4'hF, 3'b000, 2'b00);
        @(posedge clk); #1;
        n_cmp++; if (address_o !== 32'h40) begin n_fail++; $display("FAIL rw_new_addr: got %h want 40", address_o); end
        read_ack_i = 1'b1; rd_data_i = 32'hA5A55A5A;
        @(posedge clk); #1 read_ack_i = 1'b0;
        n_cmp++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL rw_new_ack: got %b want 1", wb_ack_o); end
        n_cmp++; if (wb_dat_o !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rw_new_dat: got %h want a5a55a5a", wb_dat_o); end
        @(posedge clk); #1;
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL rw_new_ack_low: got %b want 0", wb_ack_o); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_classic_write();
        test_classic_read_delay();
        test_burst_write();
        test_partial_write();
        test_error();
        test_wrap_burst_read();
        test_reset_in_wait();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/msi_wb_bfm_slave.md
# msi_wb_bfm_slave

Behavioural Wishbone B3 slave bus-functional model for simulation benches. It handles the pin-level Wishbone handshake and exposes each transfer to a parent model through tasks and state variables. The parent model decides data, wait states and error responses; examples are a BFM memory or a peripheral model. It is simulation-only; synthesis of the task layer is not required.

## Interface
- AW, 32, address width in bits
- DW, 32, data width in bits; must be a multiple of 8
- DEBUG, 0, when nonzero each beat prints time, operation, address, data and mask
- wb_clk  input  1  bus clock; all sampling on rising edge
- wb_rst  input  1  reset, asynchronous and active-high
- wb_adr_i  input  AW  byte address
- wb_dat_i  input  DW  write data
- wb_sel_i  input  DW/8  byte-lane select
- wb_we_i  input  1  1 = write, 0 = read
- wb_bte_i  input  2  burst type extension; passed through for the parent's address computation
- wb_cti_i  input  3  cycle type identifier
- wb_cyc_i  input  1  cycle valid
- wb_stb_i  input  1  strobe
- wb_dat_o  output  DW  read data
- wb_ack_o  output  1  normal termination
- wb_err_o  output  1  error termination
- wb_rty_o  output  1  retry; tied to 0

## Operation
- Encodings: op is WRITE=1 or READ=0.
- Encodings: cycle_type is CLASSIC_CYCLE=0 or BURST_CYCLE=1.
- cti encodings: 000 classic, 001 constant burst, 010 incrementing burst, 111 end-of-burst.
- Public state visible to the parent:
  - address [AW-1:0]
  - op
  - mask [DW/8-1:0]
  - cycle_type
  - has_next
- Task init(): block until reset is low and cyc_i & stb_i are sampled high on a rising edge.
  - address = wb_adr_i, op = wb_we_i, mask = wb_sel_i.
  - cycle_type = BURST if cti is 001 or 010, else CLASSIC.
  - has_next = 1.
- Task write_ack(output data): wait until stb_i is high, then return data = wb_dat_i and refresh mask = wb_sel_i.
  - Assert ack for exactly one clock.
- Task read_ack(input data): drive wb_dat_o = data and assert ack for exactly one clock.
- Task error_response(): assert err for exactly one clock; set has_next = 0.
- has_next after each ack:
  - CLASSIC: 0.
  - BURST: 1 unless cti sampled at the ack edge was 111, or cyc_i is low.
- Address advance for bursts is the parent's responsibility; the wb_next_adr helper uses cti, bte and DW.
- op or cycle_type changes inside a burst are ignored until the next init().
- Only one of ack and err is ever asserted at a time; rty is always 0.
- The read_ack data lane is driven exactly as given; mask is informational for reads.

## Timing
- Reset (asynchronous): ack=0, err=0, rty=0, wb_dat_o=0, has_next=0. Any in-progress task terminates without acknowledging.
- ack/err are driven with nonblocking assignment just after the edge on which the task is called. They are deasserted at the following rising edge, so each response is 1 cycle wide.
- Minimum latency, request sampled to ack high: 1 cycle. The parent adds wait states by idling edges before calling read_ack or write_ack.
- wb_dat_o holds its last value between beats.
- Back-to-back burst beats: if the parent calls the next ack task immediately, ack remains high continuously. This gives 1 beat per cycle.
- cyc_i dropping mid-burst: the current ack still completes, then has_next = 0.

## Test plan
- Classic write: address 0x10, data 0xDEADBEEF, sel 1111, cti 000.
  - init returns op=WRITE, cycle_type=CLASSIC.
  - write_ack returns 0xDEADBEEF.
  - ack is high for 1 cycle; has_next=0.
- Classic read with delay 3 before read_ack(0x12345678).
  - ack rises 4 cycles after request; dat_o=0x12345678 while ack is high.
  - err and rty stay 0.
- Incrementing burst write of 4 beats (cti 010,010,010,111) starting at 0x20.
  - 4 consecutive ack cycles.
  - has_next = 1,1,1,0; returned data matches each beat.
- Partial write with sel 0101: mask reported as 0101.
- Out-of-range access answered by error_response: err high for 1 cycle, ack 0, has_next=0.
- Reset asserted asynchronously during a read wait state.
  - All outputs go to 0 immediately.
  - After release, a new classic read completes normally.
